// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and width helpers for stream arbitration blocks
// Purpose: arbiter FSM state encoding and the index-width helper used by the
//          arbiter, its interface and the rotate-priority selector.
// Ports:   none (package).
package stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // A source index always occupies at least one bit, so a single-source
    // build still has a usable o_source port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/packet_rr_arbiter_if.sv
// rtl/packet_rr_arbiter_if.sv - source-side and buffer-side stream bundle for the packet arbiter
// Purpose: groups the n_inputs source streams and the single downstream stream.
// Ports:   i_stream/i_valid/i_last/i_ready (sources), o_stream/o_valid/o_last/
//          o_ready/o_source (towards the packet buffer).
// Modports: master drives the sources and downstream ready; slave is the arbiter.
interface packet_rr_arbiter_if #(
    parameter int n_inputs = 4,
    parameter int stream_w = 32
);
    import stream_pkg::*;

    localparam int iw = idx_w(n_inputs);

    logic [n_inputs*stream_w-1:0] i_stream;
    logic [n_inputs-1:0]          i_valid;
    logic [n_inputs-1:0]          i_last;
    logic [n_inputs-1:0]          i_ready;
    logic [stream_w-1:0]          o_stream;
    logic                         o_valid;
    logic                         o_last;
    logic                         o_ready;
    logic [iw-1:0]                o_source;

    modport master (
        output i_stream, i_valid, i_last, o_ready,
        input  i_ready, o_stream, o_valid, o_last, o_source
    );

    modport slave (
        input  i_stream, i_valid, i_last, o_ready,
        output i_ready, o_stream, o_valid, o_last, o_source
    );

endinterface

// File: rtl/packet_rr_arbiter_rr_pick.sv
// rtl/packet_rr_arbiter_rr_pick.sv - combinational rotate-priority selector
// Purpose: finds the first asserted request scanning ptr, ptr+1, ... with wrap
//          modulo n; works for any n, not only powers of two.
// Ports:   req (request vector), ptr (scan start, must be < n),
//          any (some request set), idx (chosen index, 0 when none).
module rr_pick #(
    parameter int n  = 4,
    parameter int iw = 2
) (
    input  logic [n-1:0]  req,
    input  logic [iw-1:0] ptr,
    output logic          any,
    output logic [iw-1:0] idx
);

    int c;

    always_comb begin
        any = 1'b0;
        idx = '0;
        c   = 0;
        for (int i = 0; i < n; i++) begin
            // Explicit wrap instead of a modulo so non-power-of-two n stays cheap.
            c = int'(ptr) + i;
            if (c >= n) begin
                c = c - n;
            end
            if (!any && req[c]) begin
                any = 1'b1;
                idx = iw'(c);
            end
        end
    end

endmodule

// File: rtl/packet_rr_arbiter.sv
// rtl/packet_rr_arbiter.sv - packet-level round-robin arbiter feeding a packet buffer
// Purpose: grants one source for a whole packet, truncates packets longer than
//          max_packet_length beats and discards their remainder.
// Ports:   clk, rst (sync active-high), bus (slave side of packet_rr_arbiter_if),
//          clear_errors (clears sticky flag), error_packet_too_long (sticky).
module packet_rr_arbiter
    import stream_pkg::*;
#(
    parameter int n_inputs          = 4,
    parameter int stream_w          = 32,
    parameter int max_packet_length = 256
) (
    input  logic               clk,
    input  logic               rst,
    packet_rr_arbiter_if.slave bus,
    input  logic               clear_errors,
    output logic               error_packet_too_long
);

    localparam int iw = idx_w(n_inputs);
    localparam int cw = $clog2(max_packet_length);

    state_t          state, state_nx;
    logic [iw-1:0]   grant, grant_nx;
    logic [iw-1:0]   rr_ptr, rr_ptr_nx;
    logic [cw-1:0]   beatcount, beatcount_nx;
    logic            err_set;

    logic            pick_any;
    logic [iw-1:0]   pick_idx;
    logic            g_valid;
    logic            g_last;
    logic            at_max;
    logic            o_hs;

    rr_pick #(
        .n  (n_inputs),
        .iw (iw)
    ) u_rr_pick (
        .req (bus.i_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign g_valid = bus.i_valid[grant];
    assign g_last  = bus.i_last[grant];
    assign at_max  = (beatcount == cw'(max_packet_length - 1));
    assign o_hs    = bus.o_valid && bus.o_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= ST_IDLE;
            grant                 <= '0;
            rr_ptr                <= '0;
            beatcount             <= '0;
            error_packet_too_long <= 1'b0;
        end else begin
            state     <= state_nx;
            grant     <= grant_nx;
            rr_ptr    <= rr_ptr_nx;
            beatcount <= beatcount_nx;
            // A new truncation outranks a simultaneous clear.
            if (err_set) begin
                error_packet_too_long <= 1'b1;
            end else if (clear_errors) begin
                error_packet_too_long <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        grant_nx     = grant;
        rr_ptr_nx    = rr_ptr;
        beatcount_nx = beatcount;
        err_set      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_nx     = pick_idx;
                    rr_ptr_nx    = (pick_idx == iw'(n_inputs - 1)) ? '0 : pick_idx + 1'b1;
                    beatcount_nx = '0;
                    state_nx     = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (o_hs && !bus.o_last) begin
                    beatcount_nx = beatcount + 1'b1;
                end
                // A genuine last on the max beat ends the packet cleanly.
                if (o_hs && g_last) begin
                    state_nx = ST_IDLE;
                end else if (o_hs && at_max) begin
                    err_set  = 1'b1;
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (g_valid && g_last) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.i_ready  = '0;
        bus.o_valid  = 1'b0;
        bus.o_last   = 1'b0;
        bus.o_stream = bus.i_stream[int'(grant)*stream_w +: stream_w];
        bus.o_source = grant;
        case (state)
            ST_LOCKED: begin
                bus.o_valid        = g_valid;
                bus.o_last         = g_last || at_max;
                bus.i_ready[grant] = bus.o_ready;
            end
            ST_DRAIN: begin
                // Remainder of a truncated packet is swallowed without downstream.
                bus.i_ready[grant] = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// tb/tb_packet_rr_arbiter.sv - randomized self-checking bench for packet_rr_arbiter
module tb_packet_rr_arbiter;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int MAXL = 8;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst;
    logic clear_errors;
    logic error_packet_too_long;

    always #5 clk = ~clk;

    packet_rr_arbiter_if #(.n_inputs(N), .stream_w(W)) bus ();

    packet_rr_arbiter #(
        .n_inputs          (N),
        .stream_w          (W),
        .max_packet_length (MAXL)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .bus                   (bus),
        .clear_errors          (clear_errors),
        .error_packet_too_long (error_packet_too_long)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Source models: each source walks through packets of random length.
    int s_pkt  [N];
    int s_beat [N];
    int s_len  [N];
    bit s_vld  [N];

    // Reference model: who owns the output, beats forwarded, discarding flag.
    bit m_busy, m_drop, m_err;
    int m_owner, m_sent, m_next;

    bit           e_valid;
    bit           e_last;
    logic [N-1:0] e_ready;

    int           mask;
    int           pv;

    function automatic int new_len();
        return 1 + int'($urandom % 11);
    endfunction

    function automatic logic [31:0] beat_data(input int k);
        return {8'(k), 8'(s_pkt[k]), 16'(s_beat[k])};
    endfunction

    task automatic drive_bus();
        for (int k = 0; k < N; k++) begin
            bus.i_valid[k]          = s_vld[k];
            bus.i_last[k]           = s_vld[k] && (s_beat[k] == s_len[k] - 1);
            bus.i_stream[k*W +: W]  = beat_data(k);
        end
    endtask

    task automatic model_edge();
        bit set_err;
        bit found;
        int c;
        set_err = 1'b0;
        found   = 1'b0;
        if (rst) begin
            m_busy  = 1'b0;
            m_drop  = 1'b0;
            m_err   = 1'b0;
            m_owner = 0;
            m_next  = 0;
            m_sent  = 0;
        end else begin
            if (!m_busy) begin
                for (int i = 0; i < N; i++) begin
                    c = (m_next + i) % N;
                    if (!found && bus.i_valid[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                        m_next  = (c + 1) % N;
                        m_busy  = 1'b1;
                        m_sent  = 0;
                    end
                end
            end else if (!m_drop) begin
                if (e_valid && bus.o_ready) begin
                    if (bus.i_last[m_owner]) begin
                        m_busy = 1'b0;
                    end else if (m_sent == MAXL - 1) begin
                        m_drop  = 1'b1;
                        set_err = 1'b1;
                    end else begin
                        m_sent++;
                    end
                end
            end else if (bus.i_valid[m_owner] && bus.i_last[m_owner]) begin
                m_busy = 1'b0;
                m_drop = 1'b0;
            end
            if (set_err) begin
                m_err = 1'b1;
            end else if (clear_errors) begin
                m_err = 1'b0;
            end
        end
        // Sources see their beat taken whenever valid meets the expected ready.
        for (int k = 0; k < N; k++) begin
            if (s_vld[k] && e_ready[k]) begin
                if (s_beat[k] == s_len[k] - 1) begin
                    s_pkt[k]++;
                    s_beat[k] = 0;
                    s_len[k]  = new_len();
                end else begin
                    s_beat[k]++;
                end
                s_vld[k] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_ready = '0;
        if (m_busy && !m_drop) begin
            e_valid          = bus.i_valid[m_owner];
            e_ready[m_owner] = bus.o_ready;
            e_last           = bus.i_last[m_owner] || (m_sent == MAXL - 1);
        end else if (m_busy && m_drop) begin
            e_ready[m_owner] = 1'b1;
        end
        check_eq("o_valid", 32'(bus.o_valid), 32'(e_valid));
        check_eq("i_ready", 32'(bus.i_ready), 32'(e_ready));
        check_eq("o_source", 32'(bus.o_source), 32'(m_owner));
        check_eq("error", 32'(error_packet_too_long), 32'(m_err));
        if (e_valid) begin
            check_eq("o_stream", bus.o_stream, beat_data(m_owner));
            check_eq("o_last", 32'(bus.o_last), 32'(e_last));
        end
    endtask

    initial begin
        rst          = 1'b1;
        clear_errors = 1'b0;
        bus.o_ready  = 1'b0;
        e_valid      = 1'b0;
        e_last       = 1'b0;
        e_ready      = '0;
        m_busy       = 1'b0;
        m_drop       = 1'b0;
        m_err        = 1'b0;
        m_owner      = 0;
        m_sent       = 0;
        m_next       = 0;
        for (int k = 0; k < N; k++) begin
            s_pkt[k]  = 0;
            s_beat[k] = 0;
            s_len[k]  = new_len();
            s_vld[k]  = 1'b0;
        end
        drive_bus();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            model_edge();
            #1;
            rst = (cyc < 3) || (cyc == 2000) || (cyc == 2600);
            if (cyc < 600) begin
                mask = 4'b0100;
                pv   = 100;
            end else if (cyc < 1400) begin
                mask = 4'b1111;
                pv   = 100;
            end else begin
                mask = 4'b1111;
                pv   = 40;
            end
            bus.o_ready  = (cyc < 1400) ? 1'b1 : (($urandom % 100) < 70);
            clear_errors = (($urandom % 100) < 5);
            for (int k = 0; k < N; k++) begin
                if (!s_vld[k] && mask[k] && (($urandom % 100) < pv)) begin
                    s_vld[k] = 1'b1;
                end
            end
            drive_bus();
            @(negedge clk);
            check_outputs();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/packet_rr_arbiter.md
Name: packet_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one store-and-forward packet buffer input between n_inputs ready/valid/last stream sources.
- Grants one source for a whole packet and releases the grant only after the last beat.
- Enforces max_packet_length at the buffer input: overlong packets are truncated and the remainder is discarded.
- Sits directly upstream of the packet buffer; its o_* ports connect to the buffer's i_* ports.

Parameters:
- n_inputs, 4, number of requesting sources (>=1, need not be a power of two)
- stream_w, 32, data beat width
- max_packet_length, 256, max beats per packet forwarded downstream (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_stream  in  n_inputs*stream_w  source data, source k at bits [k*stream_w +: stream_w]
- i_valid  in  n_inputs  per-source valid
- i_last  in  n_inputs  per-source last beat
- i_ready  out  n_inputs  per-source ready
- o_stream  out  stream_w  granted source data
- o_valid  out  1  output valid
- o_last  out  1  output last, includes forced last on truncation
- o_ready  in  1  downstream ready
- o_source  out  $clog2(n_inputs) (min 1)  index of the granted source, stable for the whole packet
- error_packet_too_long  out  1  sticky, set on truncation
- clear_errors  in  1  clears sticky error

Behaviour:
- Handshake: i_hs[k] = i_valid[k] && i_ready[k]; o_hs = o_valid && o_ready. Sources must hold data stable while valid && !ready.
- State registers: state {IDLE, LOCKED, DRAIN}, grant, rr_ptr, beatcount ($clog2(max_packet_length) bits).
- Reset: state=IDLE, grant=0, rr_ptr=0, beatcount=0, error_packet_too_long=0. All outputs are therefore 0 after reset: o_valid=0, i_ready=0, o_last=0, o_source=0.
- Reset mid-packet abandons the packet silently. The downstream buffer must be reset in the same cycle.
- IDLE:
  - If any i_valid, pick the first k with i_valid[k], scanning rr_ptr, rr_ptr+1, ... with wrap modulo n_inputs.
  - Register grant<=k, rr_ptr<=(k+1) mod n_inputs (explicit compare for non-power-of-two n_inputs), beatcount<=0, state<=LOCKED.
  - No beat is transferred in IDLE. This costs one bubble cycle per packet.
  - If no i_valid, stay in IDLE; rr_ptr is unchanged.
- LOCKED (combinational outputs from grant):
  - o_valid = i_valid[grant]; o_stream = granted slice.
  - i_ready[grant] = o_ready; all other i_ready = 0.
  - at_max = (beatcount == max_packet_length-1); o_last = i_last[grant] || at_max.
  - On o_hs && !o_last: beatcount+1.
  - On o_hs && i_last[grant]: state<=IDLE. This takes priority over truncation when i_last is asserted on the max beat, which is legal and is not an error.
  - On o_hs && at_max && !i_last[grant]: error_packet_too_long<=1, state<=DRAIN.
- DRAIN:
  - o_valid=0; i_ready[grant]=1 (discard regardless of o_ready); other i_ready=0.
  - On i_hs[grant] && i_last[grant]: state<=IDLE.
- o_source = grant in every state.
- Error flag: set wins over clear_errors in the same cycle; otherwise clear_errors clears it; rst clears it.
- Fairness: a source requesting continuously is granted at most once per n_inputs grants while others request.
- n_inputs=1: o_source width 1, constant 0; behaviour otherwise identical.
- Latency: zero-cycle combinational path data/valid→o and o_ready→i_ready within a packet. There is no registered datapath.

Decomposition:
- Shared package stream_pkg holds:
  - state enum (ST_IDLE, ST_LOCKED, ST_DRAIN)
  - width helper function/constant for index width (max(1,$clog2(n)))
- One sub-module, rr_pick: combinational rotate-priority selector.
  - Inputs: req[n_inputs], ptr.
  - Outputs: any, idx.
  - Reusable by later schedulers.

Test Plan (n_inputs=4, stream_w=32, max_packet_length=8):
- Single source: src2 sends 3-beat packet 0xA0..0xA2, o_ready=1.
  - Required: one IDLE bubble, then o_stream A0,A1,A2; o_last only on A2; o_source=2; rr_ptr=3 afterwards.
- Round-robin: all four sources continuously offer 2-beat packets.
  - Required: grant order 0,1,2,3,0; no source granted twice in a row; 3 cycles per packet.
- Backpressure: src1 4-beat packet, o_ready toggled 1,0,0,1...
  - Required: i_ready[1] mirrors o_ready; no beat lost or duplicated; src0 valid meanwhile keeps i_ready[0]=0.
- Exact max: src0 sends 8 beats, i_last on beat 8.
  - Required: 8 beats out, o_last on beat 8, error stays 0.
- Truncation: src3 sends 11 beats.
  - Required: 8 beats out, o_last forced on beat 8, error=1.
  - Beats 9–11 consumed with o_valid=0; next grant only after beat 11.
  - clear_errors asserted on the set cycle leaves error=1; asserted later clears it.
- Reset mid-packet: rst on beat 2 of src1's packet.
  - Required: next cycle o_valid=0, all i_ready=0, o_source=0, error=0; next arbitration starts from rr_ptr=0.
